// File: rtl/butterfly_result_packer_pkg.sv
// butterfly_result_packer_pkg: shared FSM encoding, default geometry and slot/lane offset helpers
// Contents: state_e (IDLE/RUN/DRAIN), default parameter values, re_off/im_off bit-offset helpers.
package butterfly_result_packer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam int DEF_DW = 16;
  localparam int DEF_P = 4;
  localparam int DEF_K = 4;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_BEAT_W = 2 * DEF_DW * DEF_P * DEF_K;
  localparam int LEN_W = 16;
  // Each (slot, lane) pair owns one complex sample: real in the low half, imaginary above it.
  function automatic int re_off(input int s, input int p, input int lanes, input int dw);
    return (s * lanes + p) * 2 * dw;
  endfunction
  function automatic int im_off(input int s, input int p, input int lanes, input int dw);
    return re_off(s, p, lanes, dw) + dw;
  endfunction
endpackage

// File: rtl/butterfly_result_packer_if.sv
// butterfly_result_packer_if: engine-side serial streams and downstream beat bus of the packer
// Signals: in_vld/in_dat/in_rdy for real (A) and imaginary (B) lanes; dn_vld/dn_dat/dn_last/dn_rdy.
// master = engine + writeback side (drives inputs, dn_rdy); slave = packer.
interface butterfly_result_packer_if
  import butterfly_result_packer_pkg::*;
#(
  parameter int data_width = DEF_DW,
  parameter int parallelism_per_control = DEF_P,
  parameter int pack_factor = DEF_K
);
  localparam int P = parallelism_per_control;
  localparam int BW = 2 * data_width * P * pack_factor;
  logic [P-1:0] in_vld_A;
  logic [data_width*P-1:0] in_dat_A;
  logic in_rdy_A;
  logic [P-1:0] in_vld_B;
  logic [data_width*P-1:0] in_dat_B;
  logic in_rdy_B;
  logic dn_vld;
  logic [BW-1:0] dn_dat;
  logic dn_last;
  logic dn_rdy;
  modport master (
    output in_vld_A, in_dat_A, in_vld_B, in_dat_B, dn_rdy,
    input  in_rdy_A, in_rdy_B, dn_vld, dn_dat, dn_last
  );
  modport slave (
    input  in_vld_A, in_dat_A, in_vld_B, in_dat_B, dn_rdy,
    output in_rdy_A, in_rdy_B, dn_vld, dn_dat, dn_last
  );
endinterface

// File: rtl/bf_sync_fifo.sv
// bf_sync_fifo: show-ahead synchronous FIFO with full/empty flags
// Ports: clk, rst_n (async, active-low), push_i/wdata_i, pop_i, rdata_o (head entry), full_o, empty_o.
module bf_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_q, rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q[AW-1:0]] <= wdata_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/butterfly_result_packer.sv
// butterfly_result_packer: packs K elements per lane of the engine's real/imag streams into wide beats
// Ports: clk, rst_n (async, active-low), start_i/length_i (transfer setup), bus (slave side of
// butterfly_result_packer_if: input streams A/B and downstream beat bus), busy_o, done_o.
module butterfly_result_packer
  import butterfly_result_packer_pkg::*;
#(
  parameter int data_width = DEF_DW,
  parameter int parallelism_per_control = DEF_P,
  parameter int pack_factor = DEF_K,
  parameter int fifo_depth = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [LEN_W-1:0]       length_i,
  butterfly_result_packer_if.slave bus,
  output logic                   busy_o,
  output logic                   done_o
);
  localparam int DW = data_width;
  localparam int P = parallelism_per_control;
  localparam int K = pack_factor;
  localparam int BW = 2 * DW * P * K;
  localparam int SW = $clog2(K);
  state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [SW-1:0] slot_q;
  logic [BW-1:0] pack_q, pack_d;
  logic zero_q;
  logic full, empty, in_rdy, accept, final_e, push, pop, head_last;
  logic [BW:0] head;
  // Ready is independent of dn_rdy: input is simply blocked whenever the FIFO is full.
  assign in_rdy = (state_q == RUN) && !full;
  assign accept = (&bus.in_vld_A) && (&bus.in_vld_B) && in_rdy;
  assign final_e = accept && (cnt_q + 16'd1 == len_q);
  assign push = accept && ((slot_q == SW'(K - 1)) || final_e);
  assign pop = !empty && bus.dn_rdy;
  assign head_last = head[BW];
  assign bus.in_rdy_A = in_rdy;
  assign bus.in_rdy_B = in_rdy;
  assign bus.dn_vld = !empty;
  assign bus.dn_dat = head[BW-1:0];
  assign bus.dn_last = head_last;
  assign busy_o = state_q != IDLE;
  assign done_o = zero_q || ((state_q == DRAIN) && pop && head_last);
  // Merge the current element into its slot so a completing push carries it.
  always_comb begin
    pack_d = pack_q;
    for (int p = 0; p < P; p++) begin
      pack_d[re_off(int'(slot_q), p, P, DW) +: DW] = bus.in_dat_A[p*DW +: DW];
      pack_d[im_off(int'(slot_q), p, P, DW) +: DW] = bus.in_dat_B[p*DW +: DW];
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (start_i && length_i != '0) ? RUN : IDLE;
      RUN:     state_d = final_e ? DRAIN : RUN;
      DRAIN:   state_d = (pop && head_last) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      zero_q  <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      slot_q  <= '0;
      pack_q  <= '0;
    end else begin
      state_q <= state_d;
      zero_q  <= (state_q == IDLE) && start_i && (length_i == '0);
      if ((state_q == IDLE) && start_i) begin
        len_q <= length_i;
        cnt_q <= '0;
      end else if (accept) cnt_q <= cnt_q + 16'd1;
      // Zeroing after each push leaves unused slots of a short final word at 0.
      if (push) begin
        pack_q <= '0;
        slot_q <= '0;
      end else if (accept) begin
        pack_q <= pack_d;
        slot_q <= slot_q + 1'b1;
      end
    end
  end
  bf_sync_fifo #(.WIDTH(BW + 1), .DEPTH(fifo_depth)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i ({final_e, pack_d}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );
endmodule

// File: tb/tb_butterfly_result_packer.sv
// tb_butterfly_result_packer: vector-table and directed checks of the packer against a beat model
module tb_butterfly_result_packer;
  localparam int DW = 16, P = 4, K = 4, D = 4, BW = 2 * DW * P * K, MAXL = 64;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, busy, done;
  logic [15:0] length = '0;
  int total = 0, bad = 0;
  logic [DW-1:0] re [MAXL][P];
  logic [DW-1:0] im [MAXL][P];
  typedef struct {int len; int mode; bit ramp; int pf; bit bs; int nb;} vec_t;
  vec_t tv [8];
  always #5 clk = ~clk;
  butterfly_result_packer_if #(.data_width(DW), .parallelism_per_control(P), .pack_factor(K)) bus ();
  butterfly_result_packer #(.data_width(DW), .parallelism_per_control(P), .pack_factor(K), .fifo_depth(D)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .length_i(length), .bus(bus), .busy_o(busy), .done_o(done)
  );
  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Expected beat b: element e = b*K+s sits in slot s, lane p; anything past length is zero.
  function automatic logic [BW-1:0] beat(input int b, input int len);
    logic [BW-1:0] w = '0;
    for (int s = 0; s < K; s++)
      for (int p = 0; p < P; p++)
        if (b * K + s < len) begin
          w[(s*P+p)*2*DW +: DW] = re[b*K+s][p];
          w[(s*P+p)*2*DW+DW +: DW] = im[b*K+s][p];
        end
    return w;
  endfunction
  task automatic fill(input int len, input bit ramp);
    for (int e = 0; e < len; e++)
      for (int p = 0; p < P; p++) begin
        re[e][p] = ramp ? DW'(e * 16 + p) : DW'($urandom);
        im[e][p] = ramp ? DW'(16'h8000 + e * 16 + p) : DW'($urandom);
      end
  endtask
  task automatic drive_elem(input int e);
    for (int p = 0; p < P; p++) begin
      bus.in_dat_A[p*DW +: DW] = re[e][p];
      bus.in_dat_B[p*DW +: DW] = im[e][p];
    end
  endtask
  task automatic idle_inputs();
    start = 1'b0;
    bus.in_vld_A = '0;
    bus.in_vld_B = '0;
    bus.dn_rdy = 1'b0;
  endtask
  // mode: 0 dn_rdy high, 1 random dn_rdy, 2 dn_rdy held low 40 cycles, 3 random partial valids
  task automatic run(input int len, input int mode, input bit ramp, input int pf, input bit bs, input int exp_nb);
    int ei = 0, nb = 0, dones = 0, kacc = -1, fvld = -1, idx;
    bit fin = 0, ok = 0, acc;
    fill(len, ramp);
    start = 1'b1;
    length = 16'(len);
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (fin) begin
        chk("busy_after_done", BW'(busy), '0);
        ok = 1;
        break;
      end
      bus.dn_rdy = mode == 1 ? 1'($urandom % 2) : mode == 2 ? (cyc >= 40) : 1'b1;
      bus.in_vld_A = ei < len ? '1 : '0;
      bus.in_vld_B = ei < len ? '1 : '0;
      if (mode == 3 && $urandom % 3 == 0) begin
        idx = int'($urandom % P);
        bus.in_vld_B[idx] = 1'b0;
      end
      if (cyc < pf) bus.in_vld_B = 4'b1011;
      if (ei < len) drive_elem(ei);
      start = bs && cyc == 3;
      length = (bs && cyc == 3) ? 16'd2 : 16'(len);
      #1;
      if (pf > 0 && cyc == pf) chk("partial_hold", BW'(ei), '0);
      if (bus.dn_vld && fvld < 0) fvld = cyc;
      if (done) dones++;
      if (mode == 2 && cyc == 40) begin
        chk("bp_accepted", BW'(ei), BW'(D * K));
        chk("bp_in_rdy", BW'(bus.in_rdy_A), '0);
      end
      if (bus.dn_vld && bus.dn_rdy) begin
        chk("beat_dat", bus.dn_dat, beat(nb, len));
        chk("beat_last", BW'(bus.dn_last), BW'(nb == exp_nb - 1));
        chk("done_at_last", BW'(done), BW'(nb == exp_nb - 1));
        if (bus.dn_last) fin = 1;
        nb++;
      end
      acc = bus.in_rdy_A && (&bus.in_vld_A) && (&bus.in_vld_B);
      step();
      if (acc) begin
        ei++;
        if (ei == K) kacc = cyc + 1;
      end
    end
    idle_inputs();
    chk("no_timeout", BW'(ok), BW'(1));
    chk("beats", BW'(nb), BW'(exp_nb));
    chk("elems", BW'(ei), BW'(len));
    chk("done_count", BW'(dones), BW'(1));
    if (len >= K && mode == 0) chk("latency", BW'(fvld), BW'(kacc));
  endtask
  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_in_rdy"}, BW'({bus.in_rdy_A, bus.in_rdy_B}), '0);
    chk({tag, "_dn_vld"}, BW'(bus.dn_vld), '0);
    chk({tag, "_dn_last"}, BW'(bus.dn_last), '0);
    chk({tag, "_dn_dat"}, bus.dn_dat, '0);
    chk({tag, "_busy_done"}, BW'({busy, done}), '0);
  endtask
  initial begin
    tv[0] = '{8, 0, 1, 0, 0, 2};
    tv[1] = '{6, 0, 0, 0, 0, 2};
    tv[2] = '{32, 2, 1, 0, 0, 8};
    tv[3] = '{4, 0, 0, 3, 0, 1};
    tv[4] = '{12, 0, 1, 0, 1, 3};
    tv[5] = '{17, 1, 0, 0, 0, 5};
    tv[6] = '{9, 3, 0, 0, 0, 3};
    tv[7] = '{1, 0, 0, 0, 0, 1};
    bus.in_dat_A = '0;
    bus.in_dat_B = '0;
    idle_inputs();
    #1;
    chk_zero_outputs("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_zero_outputs("post_reset");
    for (int i = 0; i < 8; i++) run(tv[i].len, tv[i].mode, tv[i].ramp, tv[i].pf, tv[i].bs, tv[i].nb);
    start = 1'b1;
    length = 16'd0;
    step();
    start = 1'b0;
    chk("zero_len_done", BW'(done), BW'(1));
    chk("zero_len_busy_vld", BW'({busy, bus.dn_vld}), '0);
    step();
    chk("zero_len_done_once", BW'(done), '0);
    chk("zero_len_idle", BW'({busy, bus.dn_vld}), '0);
    fill(8, 1);
    start = 1'b1;
    length = 16'd8;
    step();
    start = 1'b0;
    for (int e = 0; e < 5; e++) begin
      bus.in_vld_A = '1;
      bus.in_vld_B = '1;
      drive_elem(e);
      step();
    end
    idle_inputs();
    #1;
    chk("pre_reset_beat_queued", BW'({busy, bus.dn_vld}), BW'(3));
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("mid_reset");
    step();
    rst_n = 1'b1;
    step();
    run(8, 0, 1, 0, 0, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
